// File: rtl/nor_flash_pkg.sv
// Shared definitions for the NOR flash responder and its controller:
// command codes, status bit positions, identifier codes and the mode enum.
package nor_flash_pkg;

    localparam logic [15:0] CMD_READ_ARRAY   = 16'h00FF;
    localparam logic [15:0] CMD_READ_STATUS  = 16'h0070;
    localparam logic [15:0] CMD_CLEAR_STATUS = 16'h0050;
    localparam logic [15:0] CMD_PROGRAM      = 16'h0010;
    localparam logic [15:0] CMD_PROGRAM_ALT  = 16'h0040;
    localparam logic [15:0] CMD_ERASE        = 16'h0020;
    localparam logic [15:0] CMD_CONFIRM      = 16'h00D0;
    localparam logic [15:0] CMD_READ_ID      = 16'h0090;

    localparam int SR_READY     = 7;
    localparam int SR_ERASE_ERR = 5;
    localparam int SR_PROG_ERR  = 4;

    localparam logic [15:0] MFR_ID = 16'h0089;
    localparam logic [15:0] DEV_ID = 16'h8817;

    typedef enum logic [2:0] {
        MODE_READ_ARRAY,
        MODE_READ_STATUS,
        MODE_READ_ID,
        MODE_PROG_SETUP,
        MODE_PROGRAMMING,
        MODE_ERASE_SETUP,
        MODE_ERASING
    } mode_t;

    function automatic logic [15:0] status_word(input logic sr7, input logic sr5, input logic sr4);
        logic [15:0] w;
        w               = '0;
        w[SR_READY]     = sr7;
        w[SR_ERASE_ERR] = sr5;
        w[SR_PROG_ERR]  = sr4;
        return w;
    endfunction

endpackage

// File: rtl/nor_flash_responder_if.sv
// Pin bundle of the NOR flash responder; the controller side is the master.
interface nor_flash_responder_if;

    logic        CE_N;
    logic        WE_N;
    logic        OE_N;
    logic        RP_N;
    logic [21:0] A;
    logic [15:0] DQ_IN;
    logic [15:0] DQ_OUT;
    logic        DQ_OE;
    logic        BUSY;

    modport master (
        output CE_N, WE_N, OE_N, RP_N, A, DQ_IN,
        input  DQ_OUT, DQ_OE, BUSY
    );

    modport slave (
        input  CE_N, WE_N, OE_N, RP_N, A, DQ_IN,
        output DQ_OUT, DQ_OE, BUSY
    );

endinterface

// File: rtl/nor_resp_array.sv
// Storage for the NOR flash responder: one asynchronous read port and one
// write port that either AND-programs a word or erases a whole block.
module nor_resp_array #(
    parameter int ADDR_W = 6,
    parameter int BLK_W  = 4
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [ADDR_W-1:0]       rd_addr,
    output logic [15:0]             rd_data,
    input  logic                    prog_en,
    input  logic [ADDR_W-1:0]       prog_addr,
    input  logic [15:0]             prog_data,
    input  logic                    erase_en,
    input  logic [ADDR_W-BLK_W-1:0] erase_blk
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [15:0] mem_q [DEPTH];
    logic [15:0] mem_d [DEPTH];

    // Programming can only clear bits, so the new word is the AND of old and new.
    always_comb begin
        mem_d = mem_q;
        if (prog_en) begin
            mem_d[prog_addr] = mem_q[prog_addr] & prog_data;
        end
        if (erase_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if ((i >> BLK_W) == int'(erase_blk)) begin
                    mem_d[i] = 16'hFFFF;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 16'hFFFF;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/nor_flash_responder.sv
// Behavioural NOR flash device responding to the standard command set.
// Define NOR_FLASH_RESPONDER_READ_ID_EN to enable the 0x0090 read-identifier command.
module nor_flash_responder
    import nor_flash_pkg::*;
#(
    parameter int ADDR_W       = 6,
    parameter int BLK_W        = 4,
    parameter int PROG_CYCLES  = 8,
    parameter int ERASE_CYCLES = 32
) (
    input  logic CLK,
    input  logic RESET,
    nor_flash_responder_if.slave bus
);

    localparam int MAX_CYCLES = (PROG_CYCLES > ERASE_CYCLES) ? PROG_CYCLES : ERASE_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

    logic              we_n_q, we_n_d;
    logic              ce_n_q, ce_n_d;
    logic [15:0]       dq_in_q, dq_in_d;
    logic [ADDR_W-1:0] a_q, a_d;
    mode_t             mode_q, mode_d;
    logic              sr7_q, sr7_d;
    logic              sr5_q, sr5_d;
    logic              sr4_q, sr4_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [15:0]       w_q, w_d;
    logic [ADDR_W-1:0] x_q, x_d;
    logic [15:0]       dq_out_q, dq_out_d;
    logic              dq_oe_q, dq_oe_d;

    logic              write_edge;
    logic              prog_en;
    logic              erase_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [15:0]       rd_data;

    // While programming, the read port is borrowed to fetch the target word for the error check.
    assign rd_addr = (mode_q == MODE_PROGRAMMING) ? x_q : bus.A[ADDR_W-1:0];

    nor_resp_array #(
        .ADDR_W (ADDR_W),
        .BLK_W  (BLK_W)
    ) u_array (
        .CLK       (CLK),
        .RESET     (RESET),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .prog_en   (prog_en),
        .prog_addr (x_q),
        .prog_data (w_q),
        .erase_en  (erase_en),
        .erase_blk (x_q[ADDR_W-1:BLK_W])
    );

    assign write_edge = !we_n_q && bus.WE_N && !ce_n_q;

    always_comb begin
        we_n_d   = bus.WE_N;
        ce_n_d   = bus.CE_N;
        dq_in_d  = bus.DQ_IN;
        a_d      = bus.A[ADDR_W-1:0];
        mode_d   = mode_q;
        sr7_d    = sr7_q;
        sr5_d    = sr5_q;
        sr4_d    = sr4_q;
        cnt_d    = cnt_q;
        w_d      = w_q;
        x_d      = x_q;
        prog_en  = 1'b0;
        erase_en = 1'b0;

        if (!bus.RP_N) begin
            mode_d = MODE_READ_ARRAY;
            sr7_d  = 1'b1;
            sr5_d  = 1'b0;
            sr4_d  = 1'b0;
            cnt_d  = '0;
        end else begin
            case (mode_q)
                MODE_READ_ARRAY, MODE_READ_STATUS, MODE_READ_ID: begin
                    if (write_edge) begin
                        case (dq_in_q)
                            CMD_READ_ARRAY:   mode_d = MODE_READ_ARRAY;
                            CMD_READ_STATUS:  mode_d = MODE_READ_STATUS;
                            CMD_CLEAR_STATUS: begin
                                sr5_d = 1'b0;
                                sr4_d = 1'b0;
                            end
                            CMD_PROGRAM, CMD_PROGRAM_ALT: mode_d = MODE_PROG_SETUP;
                            CMD_ERASE:        mode_d = MODE_ERASE_SETUP;
`ifdef NOR_FLASH_RESPONDER_READ_ID_EN
                            CMD_READ_ID:      mode_d = MODE_READ_ID;
`endif
                            default: ;
                        endcase
                    end
                end
                MODE_PROG_SETUP: begin
                    if (write_edge) begin
                        w_d    = dq_in_q;
                        x_d    = a_q;
                        sr7_d  = 1'b0;
                        cnt_d  = CNT_W'(PROG_CYCLES - 1);
                        mode_d = MODE_PROGRAMMING;
                    end
                end
                MODE_PROGRAMMING: begin
                    if (cnt_q == '0) begin
                        prog_en = 1'b1;
                        if ((w_q & ~rd_data) != 16'h0000) begin
                            sr4_d = 1'b1;
                        end
                        sr7_d  = 1'b1;
                        mode_d = MODE_READ_STATUS;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                MODE_ERASE_SETUP: begin
                    if (write_edge) begin
                        if (dq_in_q == CMD_CONFIRM) begin
                            x_d    = a_q;
                            sr7_d  = 1'b0;
                            cnt_d  = CNT_W'(ERASE_CYCLES - 1);
                            mode_d = MODE_ERASING;
                        end else begin
                            sr5_d  = 1'b1;
                            sr4_d  = 1'b1;
                            mode_d = MODE_READ_STATUS;
                        end
                    end
                end
                MODE_ERASING: begin
                    if (cnt_q == '0) begin
                        erase_en = 1'b1;
                        sr7_d    = 1'b1;
                        mode_d   = MODE_READ_STATUS;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: mode_d = MODE_READ_ARRAY;
            endcase
        end
    end

    always_comb begin
        dq_oe_d = !bus.CE_N && !bus.OE_N && bus.WE_N && bus.RP_N;
        case (mode_q)
            MODE_READ_ARRAY: dq_out_d = rd_data;
`ifdef NOR_FLASH_RESPONDER_READ_ID_EN
            MODE_READ_ID:    dq_out_d = bus.A[0] ? DEV_ID : MFR_ID;
`endif
            default:         dq_out_d = status_word(sr7_q, sr5_q, sr4_q);
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            we_n_q   <= 1'b1;
            ce_n_q   <= 1'b1;
            dq_in_q  <= '0;
            a_q      <= '0;
            mode_q   <= MODE_READ_ARRAY;
            sr7_q    <= 1'b1;
            sr5_q    <= 1'b0;
            sr4_q    <= 1'b0;
            cnt_q    <= '0;
            w_q      <= '0;
            x_q      <= '0;
            dq_out_q <= '0;
            dq_oe_q  <= 1'b0;
        end else begin
            we_n_q   <= we_n_d;
            ce_n_q   <= ce_n_d;
            dq_in_q  <= dq_in_d;
            a_q      <= a_d;
            mode_q   <= mode_d;
            sr7_q    <= sr7_d;
            sr5_q    <= sr5_d;
            sr4_q    <= sr4_d;
            cnt_q    <= cnt_d;
            w_q      <= w_d;
            x_q      <= x_d;
            dq_out_q <= dq_out_d;
            dq_oe_q  <= dq_oe_d;
        end
    end

    assign bus.DQ_OUT = dq_out_q;
    assign bus.DQ_OE  = dq_oe_q;
    assign bus.BUSY   = (mode_q == MODE_PROGRAMMING) || (mode_q == MODE_ERASING);

endmodule

// File: tb/tb_nor_flash_responder.sv
// Directed bench for nor_flash_responder with default parameters; expected
// read data goes through a scoreboard queue and is compared on return.
module tb_nor_flash_responder;

    logic CLK = 1'b0;
    logic RESET;

    always #5 CLK = ~CLK;

    nor_flash_responder_if bus ();

    nor_flash_responder dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];
    int n;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic apply_write(input logic [21:0] addr, input logic [15:0] data);
        @(negedge CLK);
        bus.CE_N  = 1'b0;
        bus.OE_N  = 1'b1;
        bus.WE_N  = 1'b0;
        bus.A     = addr;
        bus.DQ_IN = data;
        @(negedge CLK);
        bus.WE_N  = 1'b1;
        @(negedge CLK);
        bus.CE_N  = 1'b1;
    endtask

    task automatic read_check(input string tag, input logic [21:0] addr, input logic [15:0] expv);
        exp_q.push_back(expv);
        @(negedge CLK);
        bus.CE_N = 1'b0;
        bus.OE_N = 1'b0;
        bus.WE_N = 1'b1;
        bus.A    = addr;
        @(posedge CLK);
        #1;
        check({tag, "_oe"}, {15'd0, bus.DQ_OE}, 16'h0001);
        check(tag, bus.DQ_OUT, exp_q.pop_front());
        bus.CE_N = 1'b1;
        bus.OE_N = 1'b1;
    endtask

    // Counts negedges with BUSY high starting from the current one, bounded.
    task automatic wait_idle(input string tag, input int expected);
        int cycles;
        cycles = 0;
        while (bus.BUSY === 1'b1 && cycles < 500) begin
            cycles++;
            @(negedge CLK);
        end
        check(tag, 16'(cycles), 16'(expected));
    endtask

    task automatic program_word(input logic [21:0] addr, input logic [15:0] data);
        apply_write(22'h0, 16'h0040);
        apply_write(addr, data);
        wait_idle("prog_busy", 8);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.CE_N  = 1'b1;
        bus.WE_N  = 1'b1;
        bus.OE_N  = 1'b1;
        bus.RP_N  = 1'b1;
        bus.A     = '0;
        bus.DQ_IN = '0;
        RESET     = 1'b0;
        repeat (3) @(negedge CLK);
        check("reset_busy", {15'd0, bus.BUSY}, 16'h0000);
        check("reset_oe", {15'd0, bus.DQ_OE}, 16'h0000);
        check("reset_dq", bus.DQ_OUT, 16'h0000);
        RESET = 1'b1;

        read_check("read_after_reset", 22'h05, 16'hFFFF);

        // First program: watch BUSY length and the status word while busy.
        apply_write(22'h0, 16'h0010);
        apply_write(22'h05, 16'h1234);
        bus.CE_N = 1'b0;
        bus.OE_N = 1'b0;
        n = 0;
        while (bus.BUSY === 1'b1 && n < 500) begin
            n++;
            if (n == 4) begin
                check("status_while_busy", bus.DQ_OUT, 16'h0000);
            end
            @(negedge CLK);
        end
        bus.CE_N = 1'b1;
        bus.OE_N = 1'b1;
        check("prog1_busy_cycles", 16'(n), 16'd8);
        read_check("status_after_prog1", 22'h0, 16'h0080);
        apply_write(22'h0, 16'h00FF);
        read_check("array_after_prog1", 22'h05, 16'h1234);

        // Programming zeros back to ones flags SR4 and only clears bits.
        program_word(22'h05, 16'h00FF);
        read_check("status_prog_err", 22'h0, 16'h0090);
        apply_write(22'h0, 16'h0050);
        read_check("status_cleared", 22'h0, 16'h0080);
        apply_write(22'h0, 16'h00FF);
        read_check("array_and_program", 22'h05, 16'h0034);

        program_word(22'h0F, 16'h0F0F);
        program_word(22'h13, 16'h0000);
        program_word(22'h1F, 16'h5555);
        apply_write(22'h0, 16'h0020);
        apply_write(22'h13, 16'h00D0);
        wait_idle("erase_busy_cycles", 32);
        read_check("status_after_erase", 22'h0, 16'h0080);
        apply_write(22'h0, 16'h00FF);
        read_check("erase_first", 22'h10, 16'hFFFF);
        read_check("erase_mid", 22'h13, 16'hFFFF);
        read_check("erase_last", 22'h1F, 16'hFFFF);
        read_check("erase_below_block", 22'h0F, 16'h0F0F);
        read_check("erase_other_word", 22'h05, 16'h0034);

        // Bad confirm sets both error bits and leaves the block alone.
        program_word(22'h13, 16'h1111);
        apply_write(22'h0, 16'h0020);
        apply_write(22'h13, 16'h00AA);
        check("bad_confirm_busy", {15'd0, bus.BUSY}, 16'h0000);
        read_check("status_bad_confirm", 22'h0, 16'h00B0);
        apply_write(22'h0, 16'h0050);
        apply_write(22'h0, 16'h00FF);
        read_check("no_erase_on_bad_confirm", 22'h13, 16'h1111);

        // Commands issued while programming are ignored.
        apply_write(22'h0, 16'h0040);
        apply_write(22'h30, 16'h0F0F);
        apply_write(22'h0, 16'h0070);
        apply_write(22'h0, 16'h00FF);
        wait_idle("busy_tail", 2);
        read_check("status_ignored_cmds", 22'h0, 16'h0080);
        apply_write(22'h0, 16'h00FF);
        read_check("array_prog_with_cmds", 22'h30, 16'h0F0F);

        // Power-down pin in the middle of a program.
        apply_write(22'h0, 16'h0010);
        apply_write(22'h22, 16'h0000);
        @(negedge CLK);
        @(negedge CLK);
        bus.RP_N = 1'b0;
        bus.CE_N = 1'b0;
        bus.OE_N = 1'b0;
        @(negedge CLK);
        check("rp_busy", {15'd0, bus.BUSY}, 16'h0000);
        check("rp_oe", {15'd0, bus.DQ_OE}, 16'h0000);
        bus.RP_N = 1'b1;
        bus.CE_N = 1'b1;
        bus.OE_N = 1'b1;
        read_check("rp_word_unchanged", 22'h22, 16'hFFFF);
        apply_write(22'h0, 16'h0070);
        read_check("rp_status", 22'h0, 16'h0080);

        apply_write(22'h0, 16'h00FF);
        apply_write(22'h0, 16'h0090);
`ifdef NOR_FLASH_RESPONDER_READ_ID_EN
        read_check("id_device", 22'h1, 16'h8817);
        read_check("id_manufacturer", 22'h0, 16'h0089);
`else
        read_check("id_disabled_a1", 22'h1, 16'hFFFF);
        read_check("id_disabled_a5", 22'h05, 16'h0034);
`endif
        apply_write(22'h0, 16'h00FF);

        // Upper address bits alias onto the decoded range.
        read_check("addr_alias", 22'h100005, 16'h0034);

        // Reset in the middle of a program discards it and restores the array.
        apply_write(22'h0, 16'h0040);
        apply_write(22'h05, 16'h0000);
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        check("midreset_busy", {15'd0, bus.BUSY}, 16'h0000);
        check("midreset_dq", bus.DQ_OUT, 16'h0000);
        @(negedge CLK);
        RESET = 1'b1;
        read_check("midreset_array", 22'h05, 16'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
